// File: rtl/sn74163.sv
// sn74163: synchronous 4-bit binary counter with synchronous clear and parallel load.
// Pin-level model; outputs go unknown while supply pins are out of range.
module sn74163 (
    input  logic p1,   // CLR_BAR, synchronous clear, active-low
    input  logic p2,   // CLK, rising edge
    input  logic p3,   // A, data bit 0
    input  logic p4,   // B, data bit 1
    input  logic p5,   // C, data bit 2
    input  logic p6,   // D, data bit 3
    input  logic p7,   // ENP, count enable
    input  logic p8,   // GND
    input  logic p9,   // LOAD_BAR, synchronous load, active-low
    input  logic p10,  // ENT, count enable, gates RCO
    output logic p11,  // QD, bit 3
    output logic p12,  // QC, bit 2
    output logic p13,  // QB, bit 1
    output logic p14,  // QA, bit 0
    output logic p15,  // RCO
    input  logic p16   // VCC
);
    logic [3:0] q_q, q_d;
    logic       pwr_ok;
    assign pwr_ok = p16 & ~p8;
    always_comb begin
        q_d = !pwr_ok ? q_q :
              !p1     ? 4'd0 :
              !p9     ? {p6, p5, p4, p3} :
              (p7 && p10) ? q_q + 4'd1 : q_q;
    end
    always_ff @(posedge p2) begin
        q_q <= q_d;
    end
    assign {p11, p12, p13, p14} = pwr_ok ? q_q : 4'bx;
    assign p15 = pwr_ok ? (p10 & (&q_q)) : 1'bx;
endmodule

// File: tb/tb_sn74163.sv
// tb_sn74163: directed checks of clear, load, count, RCO gating, mux scan and power hold.
module tb_sn74163;
    logic p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p16;
    logic p11, p12, p13, p14, p15;
    logic [3:0] q;
    logic [7:0] mux_in;
    logic [7:0] z_seq;
    logic z;
    int n_checks, n_err;

    sn74163 dut (
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .p9(p9), .p10(p10), .p11(p11), .p12(p12), .p13(p13), .p14(p14), .p15(p15),
        .p16(p16)
    );

    initial p2 = 1'b0;
    always #5 p2 = ~p2;

    assign q = {p11, p12, p13, p14};
    assign z = mux_in[{p12, p13, p14}];

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge p2);
        #1;
    endtask

    task automatic set_data(input logic [3:0] d);
        {p6, p5, p4, p3} = d;
    endtask

    initial begin
        n_checks = 0;
        n_err = 0;
        mux_in = 8'b0100_1101;
        z_seq = 8'b0100_1101;
        p8 = 0; p16 = 1;
        p1 = 1; p9 = 0; p7 = 0; p10 = 0;
        set_data(4'b1010);
        tick();
        check("load_1010", q, 4'b1010);
        p1 = 0; p9 = 0; p7 = 1; p10 = 1;
        set_data(4'b1111);
        tick();
        check("clear_q", q, 4'b0000);
        check("clear_rco", p15, 1'b0);

        p1 = 1; p9 = 0; p7 = 0; p10 = 0;
        set_data(4'b1101);
        tick();
        check("load_1101", q, 4'b1101);
        p9 = 1;
        set_data(4'b0000);
        tick();
        check("hold_1101", q, 4'b1101);

        p1 = 0;
        tick();
        check("clear_before_count", q, 4'b0000);
        p1 = 1; p7 = 1; p10 = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("count_%0d", i), q, 4'(i % 16));
            check($sformatf("rco_%0d", i), p15, (i == 15) ? 1'b1 : 1'b0);
        end

        p9 = 0;
        set_data(4'b1111);
        tick();
        p9 = 1; p7 = 0; p10 = 1;
        tick();
        check("enp_low_hold", q, 4'b1111);
        check("enp_low_rco", p15, 1'b1);
        p10 = 0;
        #1;
        check("ent_drop_rco", p15, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("ent_low_hold", q, 4'b1111);

        p1 = 0;
        tick();
        p1 = 1; p7 = 1; p10 = 1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan_z_%0d", k), z, z_seq[k]);
            check($sformatf("scan_zbar_%0d", k), ~z, ~z_seq[k]);
            tick();
        end
        check("scan_wrap_sel", {1'b0, p12, p13, p14}, 4'b0000);
        check("scan_qd", p11, 1'b1);

        p9 = 0; p7 = 0; p10 = 0;
        set_data(4'b0101);
        tick();
        check("pwr_load", q, 4'b0101);
        p9 = 1; p7 = 1; p10 = 1;
        p16 = 0;
        tick();
        tick();
        p16 = 1;
        #1;
        check("pwr_restore", q, 4'b0101);
        tick();
        check("pwr_count", q, 4'b0110);

        #2 p1 = 0;
        #2 p1 = 1;
        tick();
        check("clr_glitch", q, 4'b0111);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
